// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: command codes,
// FSM state encoding and the default debounce length.
package calc_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_CLEAR  = 3'd1,
        CMD_RESULT = 3'd2,
        CMD_ADD    = 3'd3,
        CMD_SUB    = 3'd4,
        CMD_MULT   = 3'd5,
        CMD_DIV    = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // KEY[1]/KEY[2] have no meaning in control mode and decode to CMD_NONE
    function automatic cmd_e key_cmd(input int idx, input logic ctrl_mode);
        cmd_e c;
        c = CMD_NONE;
        if (ctrl_mode) begin
            if (idx == 0) c = CMD_CLEAR;
            else if (idx == 3) c = CMD_RESULT;
        end else begin
            case (idx)
                3:       c = CMD_ADD;
                2:       c = CMD_SUB;
                1:       c = CMD_MULT;
                default: c = CMD_DIV;
            endcase
        end
        return c;
    endfunction

    // bit order: {divide, mult, subtract, add, result_op, clear}
    function automatic logic [5:0] cmd_onehot(input cmd_e c);
        logic [5:0] r;
        case (c)
            CMD_CLEAR:  r = 6'b000001;
            CMD_RESULT: r = 6'b000010;
            CMD_ADD:    r = 6'b000100;
            CMD_SUB:    r = 6'b001000;
            CMD_MULT:   r = 6'b010000;
            CMD_DIV:    r = 6'b100000;
            default:    r = 6'b000000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// Command bus between the key sequencer (master) and the calculator datapath (slave).
interface calc_cmd_sequencer_if;
  logic       calc_busy;
  logic       clear;
  logic       result_op;
  logic       add;
  logic       subtract;
  logic       mult;
  logic       divide;
  logic       cmd_pending;
  logic       overrun;
  logic [2:0] last_cmd;

  modport master (
    input  calc_busy,
    output clear, result_op, add, subtract, mult, divide,
    output cmd_pending, overrun, last_cmd
  );

  modport slave (
    output calc_busy,
    input  clear, result_op, add, subtract, mult, divide,
    input  cmd_pending, overrun, last_cmd
  );
endinterface

// File: rtl/calc_cmd_sequencer_key_debounce.sv
// One pushbutton: two-flop synchronizer, stable-run debouncer and press detector.
// A press is only reported after the key has first been seen stably released.
module key_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_reg;
  logic [1:0]    fill_reg;
  logic          key_prev_reg;
  logic [CW-1:0] run_cnt_reg;
  logic          level_reg;
  logic          armed_reg;
  logic          press_reg;
  logic          key_s;
  logic          stable;

  assign key_s  = sync_reg[1];
  assign stable = (run_cnt_reg == RUN_MAX);
  assign press  = press_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= 2'b11;
      fill_reg     <= 2'b00;
      key_prev_reg <= 1'b1;
      run_cnt_reg  <= '0;
      level_reg    <= 1'b1;
      armed_reg    <= 1'b0;
      press_reg    <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], key_raw};
      fill_reg  <= {fill_reg[0], 1'b1};
      press_reg <= 1'b0;
      // synchronizer still holds reset values until fill_reg[1] rises
      if (!fill_reg[1]) begin
        key_prev_reg <= 1'b1;
        run_cnt_reg  <= '0;
      end else begin
        key_prev_reg <= key_s;
        if (key_s != key_prev_reg)
          run_cnt_reg <= CW'(1);
        else if (run_cnt_reg != RUN_MAX)
          run_cnt_reg <= run_cnt_reg + CW'(1);
      end
      if (stable && (key_prev_reg != level_reg)) begin
        level_reg <= key_prev_reg;
        press_reg <= armed_reg & ~key_prev_reg;
      end
      if (stable && key_prev_reg)
        armed_reg <= 1'b1;
    end
  end
endmodule

// File: rtl/calc_cmd_sequencer.sv
// Turns debounced pushbutton presses into single-cycle calculator commands,
// buffering one command while the datapath is busy.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic [3:0]           KEY,
  input  logic                 SW17,
  calc_cmd_sequencer_if.master cmd_bus
);
  logic [3:0] press;
  logic [3:0] valid_ev;
  cmd_e       win_cmd;
  logic       multi_ev;
  logic       pending_full;
  logic       issue_take;
  logic       drop;

  state_e     state_reg;
  cmd_e       pending_reg;
  cmd_e       last_cmd_reg;
  logic [5:0] pulse_reg;
  logic       overrun_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .key_raw (KEY[gi]),
        .press   (press[gi])
      );
    end
  endgenerate

  // keys meaningless in the current mode are ignored before arbitration
  always_comb begin
    valid_ev = '0;
    win_cmd  = CMD_NONE;
    for (int i = 0; i < 4; i++) begin
      if (press[i] && (key_cmd(i, SW17) != CMD_NONE)) begin
        valid_ev[i] = 1'b1;
        win_cmd     = key_cmd(i, SW17);
      end
    end
  end

  assign multi_ev     = ((valid_ev & (valid_ev - 4'd1)) != 4'd0);
  assign pending_full = (pending_reg != CMD_NONE);
  assign issue_take   = (state_reg == ST_IDLE) && pending_full &&
                        (!cmd_bus.calc_busy || (pending_reg == CMD_CLEAR));
  assign drop         = multi_ev || ((win_cmd != CMD_NONE) && (win_cmd != CMD_CLEAR) &&
                                     pending_full && !issue_take);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ST_IDLE;
      pending_reg  <= CMD_NONE;
      last_cmd_reg <= CMD_NONE;
      pulse_reg    <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      pulse_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (issue_take) begin
            state_reg    <= ST_ISSUE;
            pulse_reg    <= cmd_onehot(pending_reg);
            last_cmd_reg <= pending_reg;
          end
        end
        ST_ISSUE: state_reg <= ST_GAP;
        default:  state_reg <= ST_IDLE;
      endcase

      // a slot being vacated this cycle can accept the new event
      if (win_cmd == CMD_CLEAR)
        pending_reg <= CMD_CLEAR;
      else if ((win_cmd != CMD_NONE) && (!pending_full || issue_take))
        pending_reg <= win_cmd;
      else if (issue_take)
        pending_reg <= CMD_NONE;

      if (drop)
        overrun_reg <= 1'b1;
      else if (issue_take && (pending_reg == CMD_CLEAR))
        overrun_reg <= 1'b0;
    end
  end

  assign cmd_bus.clear       = pulse_reg[0];
  assign cmd_bus.result_op   = pulse_reg[1];
  assign cmd_bus.add         = pulse_reg[2];
  assign cmd_bus.subtract    = pulse_reg[3];
  assign cmd_bus.mult        = pulse_reg[4];
  assign cmd_bus.divide      = pulse_reg[5];
  assign cmd_bus.cmd_pending = pending_full;
  assign cmd_bus.overrun     = overrun_reg;
  assign cmd_bus.last_cmd    = last_cmd_reg;
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed scenario bench for calc_cmd_sequencer with a short debounce length.
module tb_calc_cmd_sequencer;
  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic       sw17;

  int errors = 0;
  int checks = 0;

  calc_cmd_sequencer_if bus ();

  calc_cmd_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .KEY      (key),
    .SW17     (sw17),
    .cmd_bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // bit order {divide, mult, subtract, add, result_op, clear}
  logic [5:0] pv;
  assign pv = {bus.divide, bus.mult, bus.subtract, bus.add, bus.result_op, bus.clear};

  int pulse_cnt [6] = '{default: 0};
  int multi_hot = 0;
  int cyc = 0;
  int pend_rise_cyc = -100;
  int pulse_cyc = -100;
  int add_cyc = -100;
  int sub_cyc = -100;
  logic prev_pend = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 6; i++)
      if (pv[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
    if ($countones(pv) > 1) multi_hot = multi_hot + 1;
    if (pv != 6'd0) pulse_cyc = cyc;
    if (bus.add) add_cyc = cyc;
    if (bus.subtract) sub_cyc = cyc;
    if (bus.cmd_pending && !prev_pend) pend_rise_cyc = cyc;
    prev_pend = bus.cmd_pending;
  end

  task automatic press_key(input logic [3:0] mask, input int hold);
    key = key & ~mask;
    repeat (hold) @(negedge clk);
    key = key | mask;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key = 4'hF; sw17 = 1'b0; bus.calc_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pv !== 6'd0) begin errors++; $display("FAIL reset_pulses got=%b exp=000000", pv); end
    checks++; if (bus.cmd_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", bus.cmd_pending); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    checks++; if (bus.last_cmd !== 3'd0) begin errors++; $display("FAIL reset_last_cmd got=%0d exp=0", bus.last_cmd); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_add_bounce;
    int a0, tot0, tot1;
    a0 = pulse_cnt[2];
    tot0 = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5];
    sw17 = 1'b0;
    key[3] = 1'b0; @(negedge clk);
    key[3] = 1'b1; @(negedge clk);
    press_key(4'b1000, 10);
    tot1 = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5];
    checks++; if (pulse_cnt[2] - a0 !== 1) begin errors++; $display("FAIL add_count got=%0d exp=1", pulse_cnt[2] - a0); end
    checks++; if (tot1 - tot0 !== 0) begin errors++; $display("FAIL add_others got=%0d exp=0", tot1 - tot0); end
    checks++; if (bus.last_cmd !== 3'd3) begin errors++; $display("FAIL add_last_cmd got=%0d exp=3", bus.last_cmd); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL add_overrun got=%b exp=0", bus.overrun); end
    checks++; if (pulse_cyc - pend_rise_cyc !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", pulse_cyc - pend_rise_cyc); end
    $display("test_add_bounce: add pulses=%0d last_cmd=%0d", pulse_cnt[2] - a0, bus.last_cmd);
  endtask

  task automatic test_busy_hold;
    int m0;
    m0 = pulse_cnt[4];
    bus.calc_busy = 1'b1;
    press_key(4'b0010, 10);
    checks++; if (bus.cmd_pending !== 1'b1) begin errors++; $display("FAIL busy_pending got=%b exp=1", bus.cmd_pending); end
    checks++; if (pulse_cnt[4] - m0 !== 0) begin errors++; $display("FAIL busy_no_pulse got=%0d exp=0", pulse_cnt[4] - m0); end
    bus.calc_busy = 1'b0;
    @(negedge clk);
    checks++; if (bus.mult !== 1'b1) begin errors++; $display("FAIL busy_release_mult got=%b exp=1", bus.mult); end
    checks++; if (bus.cmd_pending !== 1'b0) begin errors++; $display("FAIL busy_release_pending got=%b exp=0", bus.cmd_pending); end
    repeat (10) @(negedge clk);
    checks++; if (pulse_cnt[4] - m0 !== 1) begin errors++; $display("FAIL busy_mult_count got=%0d exp=1", pulse_cnt[4] - m0); end
    checks++; if (bus.last_cmd !== 3'd5) begin errors++; $display("FAIL busy_last_cmd got=%0d exp=5", bus.last_cmd); end
    $display("test_busy_hold: mult issued after busy drop");
  endtask

  task automatic test_overrun;
    int m0, s0;
    m0 = pulse_cnt[4]; s0 = pulse_cnt[3];
    bus.calc_busy = 1'b1;
    press_key(4'b0010, 10);
    press_key(4'b0100, 10);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
    checks++; if (bus.cmd_pending !== 1'b1) begin errors++; $display("FAIL ovr_pending got=%b exp=1", bus.cmd_pending); end
    bus.calc_busy = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (pulse_cnt[4] - m0 !== 1) begin errors++; $display("FAIL ovr_mult got=%0d exp=1", pulse_cnt[4] - m0); end
    checks++; if (pulse_cnt[3] - s0 !== 0) begin errors++; $display("FAIL ovr_sub got=%0d exp=0", pulse_cnt[3] - s0); end
    checks++; if (bus.last_cmd !== 3'd5) begin errors++; $display("FAIL ovr_last_cmd got=%0d exp=5", bus.last_cmd); end
    $display("test_overrun: overrun=%b", bus.overrun);
  endtask

  task automatic test_clear_over_busy;
    int m0, c0;
    m0 = pulse_cnt[4]; c0 = pulse_cnt[0];
    bus.calc_busy = 1'b1; sw17 = 1'b0;
    press_key(4'b0010, 10);
    sw17 = 1'b1;
    press_key(4'b0001, 10);
    checks++; if (pulse_cnt[0] - c0 !== 1) begin errors++; $display("FAIL clr_count got=%0d exp=1", pulse_cnt[0] - c0); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got=%b exp=0", bus.overrun); end
    checks++; if (bus.last_cmd !== 3'd1) begin errors++; $display("FAIL clr_last_cmd got=%0d exp=1", bus.last_cmd); end
    checks++; if (bus.cmd_pending !== 1'b0) begin errors++; $display("FAIL clr_pending got=%b exp=0", bus.cmd_pending); end
    bus.calc_busy = 1'b0; sw17 = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (pulse_cnt[4] - m0 !== 0) begin errors++; $display("FAIL clr_mult_discard got=%0d exp=0", pulse_cnt[4] - m0); end
    $display("test_clear_over_busy: clear issued while busy");
  endtask

  task automatic test_simultaneous;
    int a0, d0;
    a0 = pulse_cnt[2]; d0 = pulse_cnt[5];
    sw17 = 1'b0;
    press_key(4'b1001, 10);
    checks++; if (pulse_cnt[2] - a0 !== 1) begin errors++; $display("FAIL sim_add got=%0d exp=1", pulse_cnt[2] - a0); end
    checks++; if (pulse_cnt[5] - d0 !== 0) begin errors++; $display("FAIL sim_div got=%0d exp=0", pulse_cnt[5] - d0); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL sim_overrun got=%b exp=1", bus.overrun); end
    checks++; if (bus.last_cmd !== 3'd3) begin errors++; $display("FAIL sim_last_cmd got=%0d exp=3", bus.last_cmd); end
    $display("test_simultaneous: add wins over divide");
  endtask

  task automatic test_control_mode;
    int r0, tot0, tot1;
    r0 = pulse_cnt[1];
    sw17 = 1'b1;
    press_key(4'b1000, 10);
    checks++; if (pulse_cnt[1] - r0 !== 1) begin errors++; $display("FAIL ctl_result got=%0d exp=1", pulse_cnt[1] - r0); end
    checks++; if (bus.last_cmd !== 3'd2) begin errors++; $display("FAIL ctl_last_cmd got=%0d exp=2", bus.last_cmd); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ctl_overrun_sticky got=%b exp=1", bus.overrun); end
    tot0 = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5];
    press_key(4'b0100, 10);
    tot1 = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5];
    checks++; if (tot1 - tot0 !== 0) begin errors++; $display("FAIL ctl_ignored got=%0d exp=0", tot1 - tot0); end
    checks++; if (bus.cmd_pending !== 1'b0) begin errors++; $display("FAIL ctl_ignored_pending got=%b exp=0", bus.cmd_pending); end
    press_key(4'b0001, 10);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ctl_clear_overrun got=%b exp=0", bus.overrun); end
    checks++; if (bus.last_cmd !== 3'd1) begin errors++; $display("FAIL ctl_clear_last got=%0d exp=1", bus.last_cmd); end
    sw17 = 1'b0;
    $display("test_control_mode: result, ignored key, clear");
  endtask

  task automatic test_back_to_back;
    int a0, s0;
    a0 = pulse_cnt[2]; s0 = pulse_cnt[3];
    sw17 = 1'b0; bus.calc_busy = 1'b0;
    key[3] = 1'b0; @(negedge clk);
    key[2] = 1'b0;
    repeat (12) @(negedge clk);
    key = 4'hF;
    repeat (20) @(negedge clk);
    checks++; if (pulse_cnt[2] - a0 !== 1) begin errors++; $display("FAIL b2b_add got=%0d exp=1", pulse_cnt[2] - a0); end
    checks++; if (pulse_cnt[3] - s0 !== 1) begin errors++; $display("FAIL b2b_sub got=%0d exp=1", pulse_cnt[3] - s0); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", bus.overrun); end
    checks++; if (!(sub_cyc - add_cyc >= 2)) begin errors++; $display("FAIL b2b_spacing got=%0d exp>=2", sub_cyc - add_cyc); end
    checks++; if (multi_hot !== 0) begin errors++; $display("FAIL one_hot got=%0d exp=0", multi_hot); end
    $display("test_back_to_back: add then sub spacing=%0d", sub_cyc - add_cyc);
  endtask

  task automatic test_reset_mid_issue;
    int m0;
    int seen;
    seen = 0;
    sw17 = 1'b0; bus.calc_busy = 1'b0;
    key[1] = 1'b0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.mult === 1'b1) seen = 1;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL rst_issue_timeout got=%0d exp=1", seen); end
    rst_n = 1'b0;
    #1;
    checks++; if (pv !== 6'd0) begin errors++; $display("FAIL rst_issue_pulses got=%b exp=000000", pv); end
    checks++; if (bus.last_cmd !== 3'd0) begin errors++; $display("FAIL rst_issue_last got=%0d exp=0", bus.last_cmd); end
    m0 = pulse_cnt[4];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (pulse_cnt[4] - m0 !== 0) begin errors++; $display("FAIL rst_held_key got=%0d exp=0", pulse_cnt[4] - m0); end
    checks++; if (bus.cmd_pending !== 1'b0) begin errors++; $display("FAIL rst_held_pending got=%b exp=0", bus.cmd_pending); end
    key[1] = 1'b1;
    repeat (20) @(negedge clk);
    press_key(4'b0010, 10);
    checks++; if (pulse_cnt[4] - m0 !== 1) begin errors++; $display("FAIL rst_repress got=%0d exp=1", pulse_cnt[4] - m0); end
    $display("test_reset_mid_issue: pulse removed, re-press issued");
  endtask

  initial begin
    test_reset();
    test_add_bounce();
    test_busy_hold();
    test_overrun();
    test_clear_over_busy();
    test_simultaneous();
    test_control_mode();
    test_back_to_back();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/calc_cmd_sequencer.md
CALC_CMD_SEQUENCER -- requirements
Module: calc_cmd_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-level cycles required before a key change is accepted (10 ms at 50 MHz).
REQ-002 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  reset; asynchronous, active-low.
REQ-004 KEY  input  4  raw pushbuttons, active-low, asynchronous to CLOCK_50.
REQ-005 SW17  input  1  mode select: 1 = control mode (clear/result), 0 = operator mode.
REQ-006 calc_busy  input  1  datapath busy (multi-cycle mult/divide in progress).
REQ-007 clear, result_op, add, subtract, mult, divide  output  1 each  one-cycle command pulses to the calculator datapath.
REQ-008 cmd_pending  output  1  a captured command is waiting to be issued.
REQ-009 overrun  output  1  sticky flag: a press was dropped.
REQ-010 last_cmd  output  3  encoding of the most recently issued command (0 = none).

Function
REQ-011 Each KEY bit SHALL pass a two-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-012 A press event SHALL be a debounced 1->0 transition; each physical press yields exactly one event; release yields none.
REQ-013 Decode at the event cycle using SW17 sampled that cycle: SW17=1: KEY[0]->clear, KEY[3]->result_op, KEY[1]/KEY[2]->ignored (no flag); SW17=0: KEY[3]->add, KEY[2]->subtract, KEY[1]->mult, KEY[0]->divide.
REQ-014 Simultaneous events: priority KEY[3]>KEY[2]>KEY[1]>KEY[0]; the winner is captured, the losers are dropped and overrun is set.
REQ-015 One-entry pending register; a captured command sets cmd_pending the following cycle.
REQ-016 FSM states IDLE, ISSUE, GAP.
REQ-017 IDLE -> ISSUE when pending is full and calc_busy=0, or when pending holds clear (clear ignores calc_busy).
REQ-018 ISSUE: exactly one command output high for one cycle, pending emptied, last_cmd updated; -> GAP.
REQ-019 GAP: one cycle with all command outputs low, giving the datapath time to raise calc_busy; -> IDLE.
REQ-020 Minimum spacing between two command pulses SHALL be 2 cycles; at most one command output is high in any cycle.
REQ-021 A new non-clear event while pending is full SHALL be dropped and SHALL set overrun.
REQ-022 A clear event SHALL always replace any pending command, without setting overrun.
REQ-023 Issuing clear SHALL also clear overrun and reset last_cmd to the clear code.
REQ-024 An event in the same cycle as ISSUE empties pending SHALL be captured, not dropped.
REQ-025 Latency: debounced press to command pulse = 2 cycles when idle and not busy.
REQ-026 last_cmd codes: 0 none, 1 clear, 2 result, 3 add, 4 subtract, 5 mult, 6 divide.

Reset
REQ-027 While RESET_N=0: FSM=IDLE, pending empty, all command outputs 0, cmd_pending=0, overrun=0, last_cmd=0, synchronizer flops=1, debounced levels=1 (released), debounce counters=0.
REQ-028 Reset asserted mid-ISSUE SHALL remove the pulse immediately; no command is issued after release until a new press.
REQ-029 A key held low across reset release SHALL NOT produce an event until it is released and pressed again.

Structure
REQ-030 Shared package calc_pkg SHALL hold the last_cmd code constants, the FSM state encoding and the DEBOUNCE_CYCLES default.
REQ-031 A single sub-module key_debounce (synchronizer + counter + edge detect) SHALL be instantiated once per KEY bit.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 SW17=0, KEY[3] low for 10 cycles with 2-cycle bounce at the start -> exactly one add pulse; last_cmd=3; overrun=0.
REQ-033 calc_busy=1, press KEY[1] -> cmd_pending=1, no pulse; drop calc_busy -> mult pulse 1 cycle later; cmd_pending=0.
REQ-034 calc_busy=1, press KEY[1], then KEY[2] -> subtract dropped, overrun=1; only mult is issued after busy drops.
REQ-035 calc_busy=1, mult pending, SW17=1, press KEY[0] -> clear issued despite busy; mult discarded; overrun=0; last_cmd=1.
REQ-036 KEY[3] and KEY[0] debounce in the same cycle with SW17=0 -> add issued, divide dropped, overrun=1.
REQ-037 Drive RESET_N low during ISSUE -> all outputs 0 within the same cycle; no pulse after release.
